// File: rtl/iob_ptfloat_pack.sv
// iob_ptfloat_pack: normalizes a pt-float operand one bit per cycle, picks
// the minimal exponent-field width, rounds to nearest-even and packs it into
// {ew, exponent[ew], mantissa[DATA_W-EW_W-ew]}; zero/underflow pack to 0.
module iob_ptfloat_pack #(
  parameter  int DATA_W    = 32,
  parameter  int EW_W      = 4,
  localparam int EXP_MAX_W = 2**EW_W - 1,
  localparam int MAN_MAX_W = DATA_W - EW_W
) (
  input  logic                        clk_i,
  input  logic                        arst_n_i,
  input  logic                        cke_i,
  input  logic                        start_i,
  output logic                        ready_o,
  output logic                        done_o,
  input  logic signed [EXP_MAX_W-1:0] exp_i,
  input  logic signed [MAN_MAX_W-1:0] man_i,
  output logic        [DATA_W-1:0]    data_o
);

  localparam int SAT_MAN_W = MAN_MAX_W - EXP_MAX_W;
  localparam logic signed [EXP_MAX_W-1:0] EXP_MIN = {1'b1, {(EXP_MAX_W-1){1'b0}}};
  localparam logic signed [EXP_MAX_W-1:0] EXP_MAX = {1'b0, {(EXP_MAX_W-1){1'b1}}};
  localparam logic signed [EXP_MAX_W-1:0] EXP_ONE = EXP_MAX_W'(1);
  localparam logic        [MAN_MAX_W-1:0] MAN_ONE = MAN_MAX_W'(1);
  localparam logic        [MAN_MAX_W-1:0] MAN_HALF = {2'b01, {(MAN_MAX_W-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_OUT} state_t;

  state_t                      state;
  logic                        rnd_done;
  logic signed [EXP_MAX_W-1:0] exp_p0;
  logic signed [MAN_MAX_W-1:0] man_p0;

  logic [EW_W-1:0]      ew_cur;
  logic [MAN_MAX_W-1:0] rnd_man;
  logic                 is_zero, is_norm, at_min, at_max;
  logic                 pos_carry, neg_denorm, accept;

  // Minimal two's-complement width of e; zero needs no bits at all.
  function automatic logic [EW_W-1:0] ew_of(input logic signed [EXP_MAX_W-1:0] e);
    logic [EW_W-1:0]             w;
    logic signed [EXP_MAX_W-1:0] s;
    w = EW_W'(EXP_MAX_W);
    for (int k = EXP_MAX_W - 1; k >= 1; k--) begin
      s = e >>> (k - 1);
      if (s == '0 || s == '1) w = EW_W'(k);
    end
    if (e == '0) w = '0;
    return w;
  endfunction

  // Round-to-nearest-even dropping the low ew bits; result keeps them zero.
  function automatic logic [MAN_MAX_W-1:0] round_rne(input logic [MAN_MAX_W-1:0] m,
                                                     input logic [EW_W-1:0]      ew);
    logic [MAN_MAX_W-1:0] mask, drop, half, keep, shifted;
    logic                 up;
    mask    = (MAN_ONE << ew) - MAN_ONE;
    drop    = m & mask;
    keep    = m & ~mask;
    half    = (ew == '0) ? '0 : (MAN_ONE << (ew - 1));
    shifted = m >> ew;
    up      = (ew != '0) && ((drop > half) || ((drop == half) && shifted[0]));
    return keep + (up ? (MAN_ONE << ew) : '0);
  endfunction

  // Largest-magnitude representable word with the sign of the overflowed value.
  function automatic logic [DATA_W-1:0] sat_word(input logic neg);
    return {{EW_W{1'b1}}, EXP_MAX,
            neg ? {1'b1, {(SAT_MAN_W-1){1'b0}}} : {1'b0, {(SAT_MAN_W-1){1'b1}}}};
  endfunction

  // Place ew exponent bits right below the ew field, then the top mantissa bits.
  function automatic logic [DATA_W-1:0] pack_word(input logic signed [EXP_MAX_W-1:0] e,
                                                  input logic [MAN_MAX_W-1:0]        m,
                                                  input logic [EW_W-1:0]             ew);
    logic [MAN_MAX_W-1:0] emask, efield;
    emask  = (MAN_ONE << ew) - MAN_ONE;
    efield = (MAN_MAX_W'($unsigned(e)) & emask) << (MAN_MAX_W - ew);
    return {ew, efield | (m >> ew)};
  endfunction

  assign ready_o = (state == S_IDLE) || (state == S_OUT);

  // Decode of the held operand: normalization status and the rounding result.
  always_comb begin
    ew_cur     = ew_of(exp_p0);
    rnd_man    = rnd_done ? man_p0 : round_rne(man_p0, ew_cur);
    is_zero    = (man_p0 == '0);
    is_norm    = man_p0[MAN_MAX_W-1] ^ man_p0[MAN_MAX_W-2];
    at_min     = (exp_p0 == EXP_MIN);
    at_max     = (exp_p0 == EXP_MAX);
    pos_carry  = !man_p0[MAN_MAX_W-1] && rnd_man[MAN_MAX_W-1];
    neg_denorm = man_p0[MAN_MAX_W-1] && (rnd_man[MAN_MAX_W-1:MAN_MAX_W-2] == 2'b11) && !at_min;
    accept     = start_i && ready_o;
  end

  // Operand stage: capture, normalizing shifts and post-rounding renormalization.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (accept) begin
        exp_p0 <= exp_i;
        man_p0 <= man_i;
      end else if (state == S_NORM && !is_zero && !is_norm && !at_min) begin
        exp_p0 <= exp_p0 - EXP_ONE;
        man_p0 <= man_p0 <<< 1;
      end else if (state == S_ROUND && pos_carry && !at_max) begin
        exp_p0 <= exp_p0 + EXP_ONE;
        man_p0 <= MAN_HALF;
      end else if (state == S_ROUND && neg_denorm) begin
        exp_p0 <= exp_p0 - EXP_ONE;
        man_p0 <= rnd_man << 1;
      end
    end
  end

  // Control FSM with registered done_o/data_o.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= S_IDLE;
      rnd_done <= 1'b0;
      done_o   <= 1'b0;
      data_o   <= '0;
    end else if (cke_i) begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_NORM;
            rnd_done <= 1'b0;
          end
        end
        S_NORM: begin
          if (is_zero || (!is_norm && at_min)) begin
            data_o <= '0;
            done_o <= 1'b1;
            state  <= S_OUT;
          end else if (is_norm) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (pos_carry && at_max) begin
            data_o <= sat_word(man_p0[MAN_MAX_W-1]);
            done_o <= 1'b1;
            state  <= S_OUT;
          end else if (pos_carry || neg_denorm) begin
            rnd_done <= 1'b1;
          end else begin
            data_o <= pack_word(exp_p0, rnd_man, ew_cur);
            done_o <= 1'b1;
            state  <= S_OUT;
          end
        end
        default: begin
          if (start_i) begin
            state    <= S_NORM;
            rnd_done <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_ptfloat_pack.sv
// Directed bench for iob_ptfloat_pack (DATA_W=32, EW_W=4).
module tb_iob_ptfloat_pack;
  logic        clk = 1'b0;
  logic        arst_n, cke, start, ready, done;
  logic [14:0] exp_in;
  logic [27:0] man_in;
  logic [31:0] data;
  int          n_checks = 0;
  int          n_fail   = 0;

  iob_ptfloat_pack #(.DATA_W(32), .EW_W(4)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .start_i(start),
    .ready_o(ready), .done_o(done), .exp_i(exp_in), .man_i(man_in), .data_o(data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Present an operand for exactly one rising edge; called away from edges.
  task automatic issue(input logic [14:0] e, input logic [27:0] m);
    exp_in = e;
    man_in = m;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Latency counts the sampling edge as 1; pre = edges already spent after it.
  task automatic wait_done(input string tag, input logic [31:0] exp_data,
                           input int exp_lat, input int pre);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(n + 1 + pre), 32'(exp_lat));
    check({tag, "_data"}, data, exp_data);
  endtask

  initial begin
    int  extra;
    arst_n = 1'b0; cke = 1'b1; start = 1'b0; exp_in = '0; man_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done",  32'(done),  32'd0);
    check("rst_data",  data,       32'h0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    issue(15'h0000, 28'h4000000);  wait_done("normalized", 32'h04000000, 3, 0);
    repeat (3) @(posedge clk);
    #1;
    check("data_held", data, 32'h04000000);
    check("done_low",  32'(done), 32'd0);

    issue(15'h0003, 28'h1000000);  wait_done("two_shifts", 32'h25000000, 5, 0);
    issue(15'h0001, 28'h7FFFFFF);  wait_done("rnd_carry",  32'h34800000, 4, 0);
    issue(15'h7FFF, 28'h8000000);  wait_done("neg_m1",     32'h1C000000, 3, 0);
    issue(15'h0001, 28'hBFFFFFF);  wait_done("neg_renorm", 32'h08000000, 4, 0);
    issue(15'h0001, 28'h4000002);  wait_done("tie_even",   32'h25000000, 3, 0);
    issue(15'h0001, 28'h4000006);  wait_done("tie_odd",    32'h25000002, 3, 0);
    issue(15'h0005, 28'h0000000);  wait_done("zero",       32'h00000000, 2, 0);
    issue(15'h3FFF, 28'h7FFFFFF);  wait_done("saturate",   32'hF7FFEFFF, 3, 0);
    issue(15'h4000, 28'h2000000);  wait_done("underflow",  32'h00000000, 2, 0);
    issue(15'h0000, 28'h4000000);  wait_done("pre_uf",     32'h04000000, 3, 0);
    issue(15'h4001, 28'h1000000);  wait_done("underflow1", 32'h00000000, 3, 0);

    // Back-to-back: each new operand is presented while done_o is high.
    issue(15'h0000, 28'h4000000);  wait_done("b2b_a", 32'h04000000, 3, 0);
    issue(15'h0001, 28'h4000006);  wait_done("b2b_b", 32'h25000002, 3, 0);
    issue(15'h3FFF, 28'h7FFFFFF);  wait_done("b2b_c", 32'hF7FFEFFF, 3, 0);
    repeat (2) @(posedge clk);
    #1;

    // A start pulse while normalizing must be ignored.
    issue(15'h0003, 28'h1000000);
    exp_in = 15'h0000; man_in = 28'h4000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign_start", 32'h25000000, 5, 1);
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    check("ign_no_extra", 32'(extra), 32'd0);
    check("ign_ready",    32'(ready), 32'd1);

    // Clock enable low for five edges while in NORM.
    issue(15'h0003, 28'h1000000);
    cke = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    cke = 1'b1;
    wait_done("cke_stall", 32'h25000000, 10, 5);
    cke = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("cke_done_hold", 32'(done), 32'd1);
    check("cke_data_hold", data,      32'h25000000);
    cke = 1'b1;
    @(posedge clk); #1;
    check("cke_done_drop", 32'(done), 32'd0);

    // Asynchronous reset while in ROUND discards the operation.
    issue(15'h0001, 28'h7FFFFFF);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #2;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done",  32'(done),  32'd0);
    check("arst_data",  data,       32'h0);
    arst_n = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    check("arst_no_done", 32'(extra), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/iob_ptfloat_pack.md
# iob_ptfloat_pack

Packs an internal pt-float operand (signed exponent plus signed fractional mantissa, possibly unnormalized) into the DATA_W-bit storage word that iob_ptfloat_unpack decodes. Sits directly downstream of the arithmetic units and upstream of the register file or memory. It normalizes the mantissa one bit per cycle, selects the minimal exponent-field width, rounds to nearest-even, and handles underflow and saturation. It is multi-cycle with a start/done handshake matching the unpack stage.

## Interface
- DATA_W, 32: storage word width; must satisfy DATA_W >= EW_W + 2**EW_W + 1.
- EW_W, 4: width of the exponent-width field.
- EXP_MAX_W (localparam) = 2**EW_W - 1: internal exponent width.
- MAN_MAX_W (localparam) = DATA_W - EW_W: internal mantissa width.
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous reset, active low (asserted when 0).
- cke_i  in  1  clock enable; when low, all state is frozen.
- start_i  in  1  operand valid; sampled only when ready_o=1.
- ready_o  out  1  block can accept start_i this cycle.
- done_o  out  1  one-cycle pulse; data_o is valid.
- exp_i  in  EXP_MAX_W  two's-complement exponent.
- man_i  in  MAN_MAX_W  two's-complement fraction in [-1,1), binary point below the MSB.
- data_o  out  DATA_W  packed word; held until the next done_o.

## Operation
- Format: {ew[EW_W], exponent[ew], mantissa[DATA_W-EW_W-ew]}.
  - Value = mantissa·2^exponent, mantissa a two's-complement fraction.
  - ew=0 means exponent 0.
  - Zero is encoded as all-zeros.
- ew is the minimal two's-complement width of the exponent: exp=0 gives 0; exp=-1 gives 1; exp=1 gives 2; exp=2 gives 3.
- Normalized means man[MSB] != man[MSB-1].
- FSM states:
  - IDLE: if start_i, register exp_i/man_i, go to NORM.
  - NORM: if man==0, go to OUT with data 0. If normalized, go to ROUND. Otherwise shift man left by 1 and decrement exp. If exp is already at -2^(EXP_MAX_W-1), underflow: go to OUT with data 0.
  - ROUND: compute ew, M=MAN_MAX_W-ew. Keep the top M bits and apply RNE on the dropped bits (ties to even on kept LSB).
    - Positive carry-out (value reaches 1.0): man=0100..0, exp+1, re-enter ROUND.
    - Negative result losing normalization (top bits 11): shift left, exp-1, re-enter ROUND.
    - A re-entered pass never rounds again.
    - If exp+1 exceeds 2^(EXP_MAX_W-1)-1, saturate: ew=2**EW_W-1, exponent=max, mantissa=011..1 (positive) or 100..0 (negative).
    - Otherwise go to OUT.
  - OUT: data_o registered on entry, done_o=1. If start_i, capture the new operand and go to NORM; else go to IDLE.
- ready_o = (state==IDLE) || (state==OUT).
- start_i is ignored in NORM and ROUND.
- Reset mid-operation: immediately return to IDLE and discard the operand; no done_o follows.

## Timing
- Reset values: state IDLE, ready_o=1, done_o=0, data_o=0.
- Latency, measured in edges from the start-sampling edge to the edge raising done_o:
  - 3 for already-normalized input with no rounding carry.
  - +1 per normalization shift.
  - +1 per ROUND re-entry.
  - 2 for zero input.
  - 2+shifts for underflow.
- done_o is high exactly one cycle, unless another operation completes in the next cycle.
- Back-to-back: start_i in the OUT cycle is accepted, giving a minimum of 3 cycles per operation.
- cke_i=0 holds state, data_o and done_o unchanged. A done_o pulse lasts until the next enabled edge.

## Test plan
All scenarios use DATA_W=32, EW_W=4.
- exp=0, man=28'h4000000 -> data_o=32'h04000000, done_o 3 edges after start.
- exp=3, man=28'h1000000 (two shifts, exp becomes 1, ew=2) -> data_o=32'h25000000, latency 5.
- exp=1, man=28'h7FFFFFF (round carry, exp becomes 2, ew=3) -> data_o=32'h34800000, latency 4.
- Boundary exponents:
  - man=0, any exp -> data_o=0, latency 2.
  - exp=15'h4000, man=28'h2000000 -> underflow, data_o=0.
  - exp=15'h3FFF, man=28'h7FFFFFF -> saturate, data_o=32'hF7FFEFFF.
- Back-to-back starts issued in OUT cycles -> done_o every 3 cycles with correct words. start_i during NORM is ignored.
- Control interruptions:
  - cke_i low for 5 cycles mid-NORM -> latency extended by 5, same result.
  - arst_n_i pulsed low mid-ROUND -> outputs return to reset values and no done_o follows.
